// File: rtl/omp_result_reader_if.sv
// Output stream of the RAM_S result reader: one coefficient per beat, tagged
// with its RAM_S index and an end-of-drain marker.
interface omp_result_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/omp_result_reader.sv
// Drains RAM_S sequentially after the OMP core finishes and streams each
// coefficient with its index through a 2-entry FIFO that absorbs backpressure.
module omp_result_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int SKIP_ZERO = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   RAM_S_A,
    output logic                RAM_S_OE,
    input  logic [DATA_W-1:0]   RAM_S_Q,
    omp_result_reader_if.master out_s,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     nz_count
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Tag of the read currently in flight (data arrives on RAM_S_Q next cycle)
    logic              pend_q;
    logic [ADDR_W-1:0] pend_idx_q;
    logic              pend_last_q;

    logic [DATA_W-1:0] ent_data_q [2];
    logic [ADDR_W-1:0] ent_idx_q  [2];
    logic              ent_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q, occ_d;
    logic [ADDR_W:0]   nz_q, nz_d;

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_idx;
    logic              head_last;
    logic              pop;
    logic              push;
    logic              drop_zero;
    logic [2:0]        committed;
    logic              issue;
    logic              start_ok;

    assign head_valid = (occ_q != 2'd0);
    assign head_data  = ent_data_q[rd_ptr_q];
    assign head_idx   = ent_idx_q[rd_ptr_q];
    assign head_last  = ent_last_q[rd_ptr_q];

    assign pop       = head_valid & out_s.out_ready;
    assign drop_zero = (SKIP_ZERO != 0) && (RAM_S_Q == '0) && !pend_last_q;
    assign push      = pend_q & !drop_zero;
    assign start_ok  = (state_q == ST_IDLE) && start;

    // Words already committed to the FIFO after this cycle's pop; a new read
    // is only issued when the FIFO is guaranteed a free slot for its data.
    assign committed = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign issue     = (state_q == ST_READ) && (committed < 3'd2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        nz_d  = nz_q;
        if (start_ok) begin
            nz_d = '0;
        end else if (pop && (head_data != '0)) begin
            nz_d = nz_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_last_q <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            nz_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_q      <= issue;
            pend_idx_q  <= addr_q;
            pend_last_q <= (addr_q == LAST_ADDR);
            occ_q       <= occ_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            nz_q        <= nz_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_ent
            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_data_q[gi] <= '0;
                    ent_idx_q[gi]  <= '0;
                    ent_last_q[gi] <= 1'b0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    ent_data_q[gi] <= RAM_S_Q;
                    ent_idx_q[gi]  <= pend_idx_q;
                    ent_last_q[gi] <= pend_last_q;
                end
            end
        end
    endgenerate

    assign RAM_S_A         = addr_q;
    assign RAM_S_OE        = issue;
    assign out_s.out_valid = head_valid;
    assign out_s.out_data  = head_data;
    assign out_s.out_index = head_idx;
    assign out_s.out_last  = head_last;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FIN);
    assign nz_count        = nz_q;
endmodule

// File: tb/tb_omp_result_reader.sv
// Scoreboard bench for omp_result_reader: three instances (DEPTH=256 plain,
// DEPTH=256 zero-skipping, DEPTH=2) each with a RAM_S model and stream monitor.
module tb_omp_result_reader;
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: DEPTH=256, SKIP_ZERO=0 ----------------
    logic        start_a, oe_a, busy_a, done_a;
    logic [7:0]  a_a;
    logic [31:0] q_a;
    logic [8:0]  nz_a;
    logic [31:0] ram_a [256];
    exp_t        q_exp_a[$];
    exp_t        cur_a, prev_a, e_a;
    int          mode_a = 0, hs_cnt_a = 0, done_cnt_a = 0, outst_a = 0;
    int          first_hs_a = 0, last_hs_a = 0, hs_a;
    logic        stall_a = 1'b0;

    omp_result_reader_if #(.DATA_W(32), .ADDR_W(8)) if_a ();
    omp_result_reader #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .SKIP_ZERO(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .RAM_S_A(a_a), .RAM_S_OE(oe_a),
        .RAM_S_Q(q_a), .out_s(if_a), .busy(busy_a), .done(done_a), .nz_count(nz_a));

    // ---------------- instance B: DEPTH=256, SKIP_ZERO=1 ----------------
    logic        start_b, oe_b, busy_b, done_b;
    logic [7:0]  a_b;
    logic [31:0] q_b;
    logic [8:0]  nz_b;
    logic [31:0] ram_b [256];
    exp_t        q_exp_b[$];
    exp_t        cur_b, prev_b, e_b;
    int          mode_b = 0, hs_cnt_b = 0;
    logic        stall_b = 1'b0;

    omp_result_reader_if #(.DATA_W(32), .ADDR_W(8)) if_b ();
    omp_result_reader #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .SKIP_ZERO(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .RAM_S_A(a_b), .RAM_S_OE(oe_b),
        .RAM_S_Q(q_b), .out_s(if_b), .busy(busy_b), .done(done_b), .nz_count(nz_b));

    // ---------------- instance C: DEPTH=2, SKIP_ZERO=0 ----------------
    logic        start_c, oe_c, busy_c, done_c;
    logic [7:0]  a_c;
    logic [31:0] q_c;
    logic [8:0]  nz_c;
    logic [31:0] ram_c [256];
    exp_t        q_exp_c[$];
    exp_t        cur_c, prev_c, e_c;
    int          mode_c = 0, hs_cnt_c = 0, outst_c = 0, oe_cnt_c = 0, last_hs_c = 0, hs_c;
    logic        stall_c = 1'b0;

    omp_result_reader_if #(.DATA_W(32), .ADDR_W(8)) if_c ();
    omp_result_reader #(.DATA_W(32), .ADDR_W(8), .DEPTH(2), .SKIP_ZERO(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .RAM_S_A(a_c), .RAM_S_OE(oe_c),
        .RAM_S_Q(q_c), .out_s(if_c), .busy(busy_c), .done(done_c), .nz_count(nz_c));

    // Synchronous-read RAM_S models
    always @(posedge clk) begin
        if (oe_a) q_a <= ram_a[a_a];
        if (oe_b) q_b <= ram_b[a_b];
        if (oe_c) q_c <= ram_c[a_c];
    end

    // Downstream ready: 0 = held low, 1 = held high, 2 = pseudo-random
    always @(posedge clk) begin
        #1;
        if_a.out_ready = (mode_a == 2) ? 1'($urandom_range(0, 1)) : (mode_a == 1);
        if_b.out_ready = (mode_b == 2) ? 1'($urandom_range(0, 1)) : (mode_b == 1);
        if_c.out_ready = (mode_c == 2) ? 1'($urandom_range(0, 1)) : (mode_c == 1);
    end

    // Monitors: handshakes pop the scoreboard; stalled words must hold; reads
    // must never be issued with two words already outstanding.
    always @(negedge clk) begin
        if (rst) begin
            q_exp_a.delete(); outst_a = 0; stall_a = 1'b0;
        end else begin
            cur_a = '{data: if_a.out_data, idx: if_a.out_index, last: if_a.out_last};
            hs_a  = (if_a.out_valid && if_a.out_ready) ? 1 : 0;
            if (stall_a) begin
                compared++;
                if (!if_a.out_valid || cur_a !== prev_a) begin
                    mismatched++;
                    $display("FAIL a_stable got %h required %h", cur_a, prev_a);
                end
            end
            if (hs_a == 1) begin
                compared++;
                if (q_exp_a.size() == 0) begin
                    mismatched++;
                    $display("FAIL a_extra got idx %0d required no word", if_a.out_index);
                end else begin
                    e_a = q_exp_a.pop_front();
                    if (cur_a !== e_a) begin
                        mismatched++;
                        $display("FAIL a_word got %h required %h", cur_a, e_a);
                    end
                end
                if (hs_cnt_a == 0) first_hs_a = cyc;
                last_hs_a = cyc;
                hs_cnt_a++;
            end
            if (oe_a) begin
                compared++;
                if (outst_a - hs_a >= 2) begin
                    mismatched++;
                    $display("FAIL a_oe_outstanding got %0d required <2", outst_a - hs_a);
                end
            end
            outst_a = outst_a + (oe_a ? 1 : 0) - hs_a;
            if (done_a) done_cnt_a++;
            stall_a = if_a.out_valid && !if_a.out_ready;
            prev_a  = cur_a;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_exp_b.delete(); stall_b = 1'b0;
        end else begin
            cur_b = '{data: if_b.out_data, idx: if_b.out_index, last: if_b.out_last};
            if (stall_b) begin
                compared++;
                if (!if_b.out_valid || cur_b !== prev_b) begin
                    mismatched++;
                    $display("FAIL b_stable got %h required %h", cur_b, prev_b);
                end
            end
            if (if_b.out_valid && if_b.out_ready) begin
                compared++;
                if (q_exp_b.size() == 0) begin
                    mismatched++;
                    $display("FAIL b_extra got idx %0d required no word", if_b.out_index);
                end else begin
                    e_b = q_exp_b.pop_front();
                    if (cur_b !== e_b) begin
                        mismatched++;
                        $display("FAIL b_word got %h required %h", cur_b, e_b);
                    end
                end
                hs_cnt_b++;
            end
            stall_b = if_b.out_valid && !if_b.out_ready;
            prev_b  = cur_b;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_exp_c.delete(); outst_c = 0; stall_c = 1'b0;
        end else begin
            cur_c = '{data: if_c.out_data, idx: if_c.out_index, last: if_c.out_last};
            hs_c  = (if_c.out_valid && if_c.out_ready) ? 1 : 0;
            if (stall_c) begin
                compared++;
                if (!if_c.out_valid || cur_c !== prev_c) begin
                    mismatched++;
                    $display("FAIL c_stable got %h required %h", cur_c, prev_c);
                end
            end
            if (hs_c == 1) begin
                compared++;
                if (q_exp_c.size() == 0) begin
                    mismatched++;
                    $display("FAIL c_extra got idx %0d required no word", if_c.out_index);
                end else begin
                    e_c = q_exp_c.pop_front();
                    if (cur_c !== e_c) begin
                        mismatched++;
                        $display("FAIL c_word got %h required %h", cur_c, e_c);
                    end
                end
                last_hs_c = cyc;
                hs_cnt_c++;
            end
            if (oe_c) begin
                oe_cnt_c++;
                compared++;
                if (outst_c - hs_c >= 2) begin
                    mismatched++;
                    $display("FAIL c_oe_outstanding got %0d required <2", outst_c - hs_c);
                end
            end
            outst_c = outst_c + (oe_c ? 1 : 0) - hs_c;
            stall_c = if_c.out_valid && !if_c.out_ready;
            prev_c  = cur_c;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_ramp_a();
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            e = '{data: 32'(i + 1), idx: 8'(i), last: (i == 255)};
            q_exp_a.push_back(e);
        end
    endtask

    task automatic wait_done_a(input string tag);
        int t = 0;
        while (done_a !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        compared++;
        if (done_a !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_done_timeout got done=%b required 1", tag, done_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (3) tick();
        compared++;
        if ({if_a.out_valid, if_a.out_data, if_a.out_index, if_a.out_last} !== 42'd0) begin
            mismatched++;
            $display("FAIL reset_out got %h required 0",
                     {if_a.out_valid, if_a.out_data, if_a.out_index, if_a.out_last});
        end
        compared++;
        if ({a_a, oe_a, busy_a, done_a, nz_a} !== 20'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl got %h required 0", {a_a, oe_a, busy_a, done_a, nz_a});
        end
        compared++;
        if ({busy_b, busy_c, if_b.out_valid, if_c.out_valid} !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_bc got %b required 0000",
                     {busy_b, busy_c, if_b.out_valid, if_c.out_valid});
        end
        rst = 1'b0;
        tick();
        $display("reset: released");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 256; i++) ram_a[i] = 32'(i + 1);
        mode_a = 1; hs_cnt_a = 0;
        push_ramp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        compared++;
        if (busy_a !== 1'b1 || if_a.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_lat1 got busy=%b valid=%b required busy=1 valid=0", busy_a, if_a.out_valid);
        end
        tick();
        compared++;
        if (if_a.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_lat2 got valid=%b required 0", if_a.out_valid);
        end
        tick();
        compared++;
        if (if_a.out_valid !== 1'b1 || if_a.out_index !== 8'd0) begin
            mismatched++;
            $display("FAIL stream_lat3 got valid=%b idx=%0d required valid=1 idx=0", if_a.out_valid, if_a.out_index);
        end
        wait_done_a("stream");
        compared++;
        if (q_exp_a.size() != 0 || hs_cnt_a != 256 || nz_a !== 9'd256) begin
            mismatched++;
            $display("FAIL stream_totals got left=%0d hs=%0d nz=%0d required 0/256/256", q_exp_a.size(), hs_cnt_a, nz_a);
        end
        compared++;
        if (cyc != last_hs_a + 1 || last_hs_a - first_hs_a != 255 || busy_a !== 1'b1) begin
            mismatched++;
            $display("FAIL stream_timing got done_gap=%0d span=%0d busy=%b required 1/255/1",
                     cyc - last_hs_a, last_hs_a - first_hs_a, busy_a);
        end
        tick();
        compared++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_after got done=%b busy=%b required 0/0", done_a, busy_a);
        end
        $display("stream: %0d words, nz=%0d", hs_cnt_a, nz_a);
    endtask

    task automatic test_backpressure();
        mode_a = 2; hs_cnt_a = 0;
        push_ramp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done_a("bp");
        compared++;
        if (q_exp_a.size() != 0 || hs_cnt_a != 256 || nz_a !== 9'd256) begin
            mismatched++;
            $display("FAIL bp_totals got left=%0d hs=%0d nz=%0d required 0/256/256", q_exp_a.size(), hs_cnt_a, nz_a);
        end
        tick();
        $display("backpressure: %0d words, nz=%0d", hs_cnt_a, nz_a);
    endtask

    task automatic test_back_to_back_start();
        int dc0;
        mode_a = 1; hs_cnt_a = 0; dc0 = done_cnt_a;
        push_ramp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (5) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done_a("dstart");
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (20) tick();
        compared++;
        if (done_cnt_a - dc0 != 1 || hs_cnt_a != 256 || busy_a !== 1'b0 || q_exp_a.size() != 0) begin
            mismatched++;
            $display("FAIL dstart got dones=%0d hs=%0d busy=%b left=%0d required 1/256/0/0",
                     done_cnt_a - dc0, hs_cnt_a, busy_a, q_exp_a.size());
        end
        $display("double_start: dones=%0d words=%0d", done_cnt_a - dc0, hs_cnt_a);
    endtask

    task automatic test_reset_midway();
        int t = 0;
        mode_a = 1; hs_cnt_a = 0;
        push_ramp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        while (hs_cnt_a < 101 && t < 1000) begin
            tick();
            t++;
        end
        mode_a = 0;
        repeat (4) tick();
        compared++;
        if (if_a.out_valid !== 1'b1 || if_a.out_index !== 8'd101) begin
            mismatched++;
            $display("FAIL mid_hold got valid=%b idx=%0d required 1/101", if_a.out_valid, if_a.out_index);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        compared++;
        if ({if_a.out_valid, if_a.out_data, if_a.out_index, if_a.out_last, a_a, oe_a, busy_a, done_a, nz_a} !== 62'd0) begin
            mismatched++;
            $display("FAIL mid_reset got valid=%b data=%h idx=%0d busy=%b oe=%b nz=%0d required all 0",
                     if_a.out_valid, if_a.out_data, if_a.out_index, busy_a, oe_a, nz_a);
        end
        tick();
        mode_a = 1; hs_cnt_a = 0;
        push_ramp_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done_a("mid");
        compared++;
        if (q_exp_a.size() != 0 || hs_cnt_a != 256 || nz_a !== 9'd256) begin
            mismatched++;
            $display("FAIL mid_redrain got left=%0d hs=%0d nz=%0d required 0/256/256", q_exp_a.size(), hs_cnt_a, nz_a);
        end
        tick();
        $display("reset_midway: redrain %0d words", hs_cnt_a);
    endtask

    task automatic test_skip_zero();
        int t = 0;
        exp_t e;
        for (int i = 0; i < 256; i++) ram_b[i] = 32'd0;
        ram_b[3] = 32'h10; ram_b[200] = 32'hFFFF_FFF0;
        e = '{data: 32'h10,        idx: 8'd3,   last: 1'b0}; q_exp_b.push_back(e);
        e = '{data: 32'hFFFF_FFF0, idx: 8'd200, last: 1'b0}; q_exp_b.push_back(e);
        e = '{data: 32'h0,         idx: 8'd255, last: 1'b1}; q_exp_b.push_back(e);
        mode_b = 1; hs_cnt_b = 0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        while (done_b !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        compared++;
        if (done_b !== 1'b1 || q_exp_b.size() != 0 || hs_cnt_b != 3 || nz_b !== 9'd2) begin
            mismatched++;
            $display("FAIL skip_totals got done=%b left=%0d hs=%0d nz=%0d required 1/0/3/2",
                     done_b, q_exp_b.size(), hs_cnt_b, nz_b);
        end
        tick();
        $display("skip_zero: %0d words, nz=%0d", hs_cnt_b, nz_b);
    endtask

    task automatic test_depth2();
        int t = 0;
        exp_t e;
        ram_c[0] = 32'hA; ram_c[1] = 32'hB;
        e = '{data: 32'hA, idx: 8'd0, last: 1'b0}; q_exp_c.push_back(e);
        e = '{data: 32'hB, idx: 8'd1, last: 1'b1}; q_exp_c.push_back(e);
        mode_c = 0; oe_cnt_c = 0; hs_cnt_c = 0;
        start_c = 1'b1; tick(); start_c = 1'b0;
        repeat (4) tick();
        mode_c = 1;
        while (done_c !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        compared++;
        if (done_c !== 1'b1 || cyc != last_hs_c + 1) begin
            mismatched++;
            $display("FAIL d2_done got done=%b gap=%0d required 1/1", done_c, cyc - last_hs_c);
        end
        compared++;
        if (oe_cnt_c != 2 || q_exp_c.size() != 0 || hs_cnt_c != 2 || nz_c !== 9'd2) begin
            mismatched++;
            $display("FAIL d2_totals got oe=%0d left=%0d hs=%0d nz=%0d required 2/0/2/2",
                     oe_cnt_c, q_exp_c.size(), hs_cnt_c, nz_c);
        end
        tick();
        $display("depth2: oe=%0d words=%0d", oe_cnt_c, hs_cnt_c);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 32'd0; ram_b[i] = 32'd0; ram_c[i] = 32'd0;
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back_start();
        test_reset_midway();
        test_skip_zero();
        test_depth2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
